// File: rtl/accumulator_readout_unit.sv
// Drains a region of accumulator rows through a 2-entry FIFO to a ready/valid stream.
// Optional build macro ACCUM_READOUT_RELU_EN clamps negative output lanes to zero.
module accumulator_readout_unit #(
  parameter int unsigned MUL_SIZE   = 32,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [ADDR_WIDTH-1:0]           base_addr_i,
  input  logic [ADDR_WIDTH:0]             row_count_i,
  output logic                            accum_rd_en_o,
  output logic [ADDR_WIDTH-1:0]           accum_rd_addr_o,
  input  logic [MUL_SIZE*ACC_WIDTH-1:0]   accum_rd_data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [MUL_SIZE*ACC_WIDTH-1:0]   out_data_o,
  output logic [ADDR_WIDTH-1:0]           out_row_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned DataW = MUL_SIZE * ACC_WIDTH;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFinish} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   issue_q, issue_d;
  logic [ADDR_WIDTH:0]   issue_inc;

  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_row_q;

  logic [DataW-1:0]      fifo_data_q [2];
  logic [ADDR_WIDTH-1:0] fifo_row_q  [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q;

  logic                  push, pop, rd_en;
  logic [1:0]            occ_committed;
  logic [DataW-1:0]      head_data;

  assign push      = inflight_q;
  assign pop       = (occ_q != 2'd0) && out_ready_i;
  assign issue_inc = issue_q + (ADDR_WIDTH+1)'(1);

  // Slots already spoken for once this cycle's pop retires; a new read may only
  // issue if its data is guaranteed a slot on arrival.
  assign occ_committed = occ_q - {1'b0, pop} + {1'b0, inflight_q};
  assign rd_en = (state_q == StRead) && (issue_q < count_q) && (occ_committed < 2'd2);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    issue_d = issue_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = base_addr_i;
          count_d = row_count_i;
          issue_d = '0;
          state_d = (row_count_i == '0) ? StFinish : StRead;
        end
      end
      StRead: begin
        if (rd_en) begin
          issue_d = issue_inc;
          if (issue_inc == count_q) state_d = StDrain;
        end
      end
      StDrain: begin
        // Last beat: the only occupant leaves and nothing is still on its way.
        if (pop && (occ_q == 2'd1) && !inflight_q) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= StIdle;
      base_q         <= '0;
      count_q        <= '0;
      issue_q        <= '0;
      inflight_q     <= 1'b0;
      inflight_row_q <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      count_q        <= count_d;
      issue_q        <= issue_d;
      inflight_q     <= rd_en;
      inflight_row_q <= issue_q[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_row_q[i]  <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= accum_rd_data_i;
        fifo_row_q[wr_ptr_q]  <= inflight_row_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    out_data_o = head_data;
`ifdef ACCUM_READOUT_RELU_EN
    for (int unsigned l = 0; l < MUL_SIZE; l++) begin
      if (head_data[l*ACC_WIDTH + ACC_WIDTH - 1]) out_data_o[l*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
`else
    out_data_o = head_data;
`endif
  end

  assign accum_rd_en_o   = rd_en;
  assign accum_rd_addr_o = base_q + issue_q[ADDR_WIDTH-1:0];
  assign out_valid_o     = (occ_q != 2'd0);
  assign out_row_o       = fifo_row_q[rd_ptr_q];
  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StFinish);

endmodule

// File: tb/tb_accumulator_readout_unit.sv
// Directed bench for accumulator_readout_unit with a one-cycle-latency accumulator model.
module tb_accumulator_readout_unit;

  localparam int Lanes = 32;
  localparam int AccW  = 32;
  localparam int AddrW = 10;
  localparam int DW    = Lanes * AccW;

  logic             clk, rst_i, start, rd_en, out_valid, out_ready, busy, done;
  logic [AddrW-1:0] base_addr, rd_addr, out_row;
  logic [AddrW:0]   row_count;
  logic [DW-1:0]    rd_data, out_data;

  accumulator_readout_unit #(
    .MUL_SIZE  (Lanes),
    .ACC_WIDTH (AccW),
    .ADDR_WIDTH(AddrW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start),
    .base_addr_i    (base_addr),
    .row_count_i    (row_count),
    .accum_rd_en_o  (rd_en),
    .accum_rd_addr_o(rd_addr),
    .accum_rd_data_i(rd_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_row_o      (out_row),
    .busy_o         (busy),
    .done_o         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane l of row a holds {a, l}; row 1000 lane 0 holds -10.
  function automatic logic [DW-1:0] mem_row(input int a);
    logic [DW-1:0] r;
    for (int l = 0; l < Lanes; l++) r[l*AccW +: AccW] = {6'd0, 10'(a), 16'(l)};
    if (a == 1000) r[31:0] = 32'hFFFF_FFF6;
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_row(input int a);
    logic [DW-1:0] r;
    r = mem_row(a);
`ifdef ACCUM_READOUT_RELU_EN
    for (int l = 0; l < Lanes; l++) if (r[l*AccW + AccW - 1]) r[l*AccW +: AccW] = '0;
`endif
    return r;
  endfunction

  function automatic int lane_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    for (int l = 0; l < Lanes; l++) if (a[l*AccW +: AccW] !== b[l*AccW +: AccW]) n++;
    return n;
  endfunction

  always @(posedge clk) rd_data <= rd_en ? mem_row(int'(rd_addr)) : {Lanes{32'hDEAD_BEEF}};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int exp_base, beats, reads, done_cnt, start_cyc;
  int first_valid_cyc, first_beat_cyc, last_beat_cyc, first_read_cyc, last_read_cyc, done_cyc;
  logic             prev_stall = 1'b0;
  logic [DW-1:0]    prev_data;
  logic [AddrW-1:0] prev_row;
  logic [31:0]      last_lane0;

  always @(negedge clk) begin
    if (!rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en) begin
        check("rd_addr", 64'(rd_addr), 64'((exp_base + reads) % 1024));
        if (reads == 0) first_read_cyc = cyc;
        last_read_cyc = cyc;
        reads++;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data", 64'(lane_diff(out_data, prev_data)), 64'(0));
        check("stall_row", 64'(out_row), 64'(prev_row));
      end
      if (out_valid && out_ready) begin
        check("beat_row", 64'(out_row), 64'(beats));
        check("beat_data", 64'(lane_diff(out_data, exp_row((exp_base + beats) % 1024))), 64'(0));
        if (beats == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        last_lane0    = out_data[31:0];
        beats++;
      end
      check("occ_le2", 64'(dut.occ_q <= 2'd2), 64'(1));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_row   = out_row;
    end
  end

  task automatic start_region(input int b, input int n);
    @(posedge clk);
    #1;
    exp_base = b; beats = 0; reads = 0; done_cnt = 0;
    first_valid_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
    first_read_cyc = -1; last_read_cyc = -1; done_cyc = -1;
    start     = 1'b1;
    base_addr = AddrW'(b);
    row_count = (AddrW+1)'(n);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs until done_o is seen or the budget expires; optional ready toggling and
  // a stray start pulse while busy, which must be ignored.
  task automatic wait_done(input string tag, input int budget, input bit toggle, input bit poke);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (toggle) out_ready = ~out_ready;
      if (poke && i == 2) begin
        start = 1'b1; base_addr = 10'd500; row_count = 11'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 64'(rd_en), 64'(0));
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_data"}, 64'(|out_data), 64'(0));
    check({tag, "_row"}, 64'(out_row), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    rst_i = 1'b0; start = 1'b0; base_addr = '0; row_count = '0; out_ready = 1'b1;
    exp_base = 0; beats = 0; reads = 0; done_cnt = 0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;

    // base 0, 4 rows, ready held: back-to-back reads and beats
    start_region(0, 4);
    wait_done("b0n4", 40, 1'b0, 1'b0);
    check("b0n4_beats", 64'(beats), 64'(4));
    check("b0n4_reads", 64'(reads), 64'(4));
    check("b0n4_read_lat", 64'(first_read_cyc - start_cyc), 64'(1));
    check("b0n4_read_span", 64'(last_read_cyc - first_read_cyc), 64'(3));
    // start sampled at cycle start_cyc+1; first beat two cycles after that
    check("b0n4_valid_lat", 64'(first_valid_cyc - start_cyc), 64'(3));
    check("b0n4_tput", 64'(last_beat_cyc - first_beat_cyc), 64'(3));
    check("b0n4_done_lag", 64'(done_cyc - last_beat_cyc), 64'(1));

    // address wrap 1022,1023,0,1
    start_region(1022, 4);
    wait_done("wrap", 40, 1'b0, 1'b0);
    check("wrap_beats", 64'(beats), 64'(4));
    check("wrap_reads", 64'(reads), 64'(4));

    // ready toggling with a stray start mid-drain
    start_region(100, 8);
    wait_done("tog", 80, 1'b1, 1'b1);
    check("tog_beats", 64'(beats), 64'(8));
    check("tog_reads", 64'(reads), 64'(8));

    // empty region
    start_region(7, 0);
    wait_done("n0", 20, 1'b0, 1'b0);
    check("n0_reads", 64'(reads), 64'(0));
    check("n0_beats", 64'(beats), 64'(0));
    check("n0_done_lat", 64'(done_cyc - start_cyc), 64'(1));

    // negative lane
    start_region(1000, 1);
    wait_done("relu", 20, 1'b0, 1'b0);
    check("relu_beats", 64'(beats), 64'(1));
`ifdef ACCUM_READOUT_RELU_EN
    check("relu_lane0", 64'(last_lane0), 64'(32'h0000_0000));
`else
    check("relu_lane0", 64'(last_lane0), 64'(32'hFFFF_FFF6));
`endif

    // reset after 3 of 16 beats, then a fresh 2-row region at base 5
    start_region(0, 16);
    for (int i = 0; i < 40 && beats < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_beats_before_rst", 64'(beats), 64'(3));
    rst_i = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    start_region(5, 2);
    wait_done("post_rst", 40, 1'b0, 1'b0);
    check("post_rst_beats", 64'(beats), 64'(2));
    check("post_rst_reads", 64'(reads), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
